// File: rtl/user_proj_timer_array_if.sv
// Wishbone classic bus bundle for the timer array; signal names follow the wrapper's wbs_* ports.
interface user_proj_timer_array_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/user_proj_timer_array.sv
// NUM_CH down-counting timers with auto-reload, W1C status and IO toggle, plus a GPIO block,
// all behind a single-cycle-latency Wishbone classic slave.
module user_proj_timer_array #(
   parameter int unsigned NUM_CH    = 3,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned IO_W      = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   user_proj_timer_array_if.slave    wbs,
   input  logic [IO_W-1:0]           io_in,
   output logic [IO_W-1:0]           io_out,
   output logic [IO_W-1:0]           io_oeb,
   output logic [NUM_CH-1:0]         irq
);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

   logic                          ack_q;
   logic [31:0]                   rdata_q;
   logic [NUM_CH-1:0][3:0]        ctrl_q, ctrl_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  load_q, load_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  count_q, count_d;
   logic [NUM_CH-1:0]             expired_q, expired_d;
   logic [IO_W-1:0]               gpio_out_q, gpio_out_d;
   logic [IO_W-1:0]               gpio_oeb_q, gpio_oeb_d;
   logic [IO_W-1:0]               gpio_in_q;

   logic        hit, req, wr_en, gl_page, ch_hit;
   logic [3:0]  ch_idx;
   logic [1:0]  reg_idx;
   logic [5:0]  gl_idx;
   logic [NUM_CH-1:0] ch_wr;
   logic [31:0] rdata;
   logic        unused_adr;

   assign hit      = wbs.wbs_adr_i[31:9] == BASE_ADDR[31:9];
   // ack_q gating prevents a held strobe from being acked twice in a row
   assign req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & ~ack_q;
   assign wr_en    = req & wbs.wbs_we_i;
   assign gl_page  = wbs.wbs_adr_i[8];
   assign ch_idx   = wbs.wbs_adr_i[7:4];
   assign reg_idx  = wbs.wbs_adr_i[3:2];
   assign gl_idx   = wbs.wbs_adr_i[7:2];
   assign ch_hit   = ~gl_page & (32'(ch_idx) < NUM_CH);
   assign unused_adr = ^wbs.wbs_adr_i[1:0];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ch_wr[g] = wr_en & ch_hit & (ch_idx == 4'(g));
      assign irq[g]   = expired_q[g] & ctrl_q[g][2];
   end

   always_comb begin
      rdata = '0;
      if (gl_page) begin
         case (gl_idx)
            6'd0:    rdata = 32'(gpio_out_q);
            6'd1:    rdata = 32'(gpio_oeb_q);
            6'd2:    rdata = 32'(gpio_in_q);
            default: rdata = '0;
         endcase
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_hit && ch_idx == 4'(c)) begin
               case (reg_idx)
                  2'd0:    rdata = 32'(ctrl_q[c]);
                  2'd1:    rdata = 32'(load_q[c]);
                  2'd2:    rdata = 32'(count_q[c]);
                  default: rdata = 32'(expired_q[c]);
               endcase
            end
         end
      end
   end

   // Order matters: W1C, then hardware events, then software writes, so that expiry beats
   // W1C and software writes beat decrement/reload/toggle on the same edge.
   always_comb begin
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      count_d    = count_q;
      expired_d  = expired_q;
      gpio_out_d = gpio_out_q;
      gpio_oeb_d = gpio_oeb_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_wr[c] && reg_idx == 2'd3 && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) begin
            expired_d[c] = 1'b0;
         end
         if (ctrl_q[c][0]) begin
            if (count_q[c] != '0) begin
               count_d[c] = count_q[c] - CNT_W'(1);
            end else begin
               expired_d[c] = 1'b1;
               if (ctrl_q[c][1]) count_d[c] = load_q[c];
               else              ctrl_d[c][0] = 1'b0;
               if (ctrl_q[c][3]) gpio_out_d[c] = ~gpio_out_q[c];
            end
         end
         if (ch_wr[c]) begin
            case (reg_idx)
               2'd0: ctrl_d[c] = 4'(merge_bytes(32'(ctrl_q[c]), wbs.wbs_dat_i, wbs.wbs_sel_i));
               2'd1: load_d[c] = CNT_W'(merge_bytes(32'(load_q[c]), wbs.wbs_dat_i,
                                                    wbs.wbs_sel_i));
               2'd2: count_d[c] = CNT_W'(merge_bytes(32'(count_q[c]), wbs.wbs_dat_i,
                                                     wbs.wbs_sel_i));
               default: ;
            endcase
         end
      end
      if (wr_en && gl_page) begin
         case (gl_idx)
            6'd0: gpio_out_d = IO_W'(merge_bytes(32'(gpio_out_d), wbs.wbs_dat_i, wbs.wbs_sel_i));
            6'd1: gpio_oeb_d = IO_W'(merge_bytes(32'(gpio_oeb_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
            default: ;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         ctrl_q     <= '0;
         load_q     <= '0;
         count_q    <= '0;
         expired_q  <= '0;
         gpio_out_q <= '0;
         gpio_oeb_q <= '1;
         gpio_in_q  <= '0;
      end else begin
         ack_q      <= req;
         rdata_q    <= (req && !wbs.wbs_we_i) ? rdata : '0;
         ctrl_q     <= ctrl_d;
         load_q     <= load_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         gpio_out_q <= gpio_out_d;
         gpio_oeb_q <= gpio_oeb_d;
         gpio_in_q  <= io_in;
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = rdata_q;
   assign io_out        = gpio_out_q;
   assign io_oeb        = gpio_oeb_q;

endmodule

// File: tb/tb_user_proj_timer_array.sv
// Directed bench for user_proj_timer_array: bus timing, timer periods, simultaneous-event
// priority, byte selects, decode window and mid-transaction reset.
module tb_user_proj_timer_array;
   localparam logic [31:0] Base = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] io_in = 16'hA5A5;
   logic [15:0] io_out, io_oeb;
   logic [2:0]  irq;
   logic [31:0] rd;
   int          n_checks = 0;
   int          n_errors = 0;

   user_proj_timer_array_if bus();

   user_proj_timer_array dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (bus),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ch_adr(input int c, input int r);
      return Base + 32'(c * 16 + r * 4);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One access: ack must come one edge after strobe, last one cycle, and dat_o idles at 0.
   task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
      int lat;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      bus.wbs_sel_i = sel;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.wbs_ack_o && lat < 8);
      rdat = bus.wbs_dat_o;
      check_eq("ack_latency", 32'(lat), 32'd1);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(posedge clk);
      #1;
      check_eq("ack_single", 32'(bus.wbs_ack_o), 32'd0);
      check_eq("dat_idle", bus.wbs_dat_o, 32'd0);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel);
      logic [31:0] dummy;
      wb_cycle(1'b1, adr, wdat, sel, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
      wb_cycle(1'b0, adr, 32'd0, 4'h0, rdat);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acks;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Reset state
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
      check_eq("rst_out", 32'(io_out), 32'd0);
      check_eq("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
      wb_read(ch_adr(0, 0), rd);       check_eq("rst_ctrl0", rd, 32'd0);
      wb_read(Base + 32'h104, rd);     check_eq("rst_gpio_oeb", rd, 32'h0000_FFFF);
      wb_read(Base + 32'h108, rd);     check_eq("gpio_in", rd, 32'h0000_A5A5);

      // ch1 auto-reload: enable commits at E0, task returns just after E1; expiry at E6
      wb_write(ch_adr(1, 1), 32'd5, 4'hF);
      wb_write(ch_adr(1, 2), 32'd5, 4'hF);
      wb_write(ch_adr(1, 0), 32'h7, 4'hF);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_eq($sformatf("ch1_first_irq_%0d", i), 32'(irq), (i == 5) ? 32'd2 : 32'd0);
      end
      // W1C commits at E7 (count=4, no expiry), so irq must be low afterwards
      wb_write(ch_adr(1, 3), 32'd1, 4'hF);
      check_eq("ch1_w1c_irq", 32'(irq), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq($sformatf("ch1_second_irq_%0d", i), 32'(irq), (i == 4) ? 32'd2 : 32'd0);
      end

      // ch0 one-shot with IO toggle: enable at B, expiry at B+4
      wb_write(Base + 32'h104, 32'd0, 4'hF);
      wb_write(ch_adr(0, 2), 32'd3, 4'hF);
      wb_write(ch_adr(0, 0), 32'h9, 4'hF);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_eq($sformatf("ch0_io_%0d", i), 32'(io_out[0]), (i == 3) ? 32'd1 : 32'd0);
      end
      check_eq("ch0_oeb", 32'(io_oeb), 32'd0);
      repeat (3) tick();
      check_eq("ch0_io_once", 32'(io_out), 32'd1);
      wb_read(ch_adr(0, 0), rd);       check_eq("ch0_ctrl_after", rd, 32'h8);
      wb_read(ch_adr(0, 2), rd);       check_eq("ch0_count_hold", rd, 32'd0);
      wb_read(ch_adr(0, 3), rd);       check_eq("ch0_status", rd, 32'd1);
      check_eq("ch0_no_irq", 32'(irq[0]), 32'd0);

      // ch2: STATUS W1C lands on the expiry edge (enable at B, expiry at B+3)
      wb_write(ch_adr(2, 2), 32'd2, 4'hF);
      wb_write(ch_adr(2, 0), 32'h1, 4'hF);
      tick();
      wb_write(ch_adr(2, 3), 32'd1, 4'hF);
      wb_read(ch_adr(2, 3), rd);       check_eq("w1c_vs_expiry", rd, 32'd1);
      wb_write(ch_adr(2, 3), 32'd1, 4'hF);
      wb_read(ch_adr(2, 3), rd);       check_eq("w1c_plain", rd, 32'd0);

      // ch2: COUNT write on a decrement edge wins; one more decrement precedes the read
      wb_write(ch_adr(2, 2), 32'd100, 4'hF);
      wb_write(ch_adr(2, 0), 32'h1, 4'hF);
      wb_write(ch_adr(2, 2), 32'h0AB, 4'hF);
      wb_read(ch_adr(2, 2), rd);       check_eq("count_wr_wins", rd, 32'h0AA);
      wb_write(ch_adr(2, 0), 32'h0, 4'hF);

      // Byte selects, unmapped offset, decode window
      wb_write(Base + 32'h100, 32'h1234_5678, 4'b0001);
      wb_read(Base + 32'h100, rd);     check_eq("gpio_bytesel", rd, 32'h0000_0078);
      check_eq("io_out_bytesel", 32'(io_out), 32'h0000_0078);
      wb_write(Base + 32'h0F0, 32'hFFFF_FFFF, 4'hF);
      wb_read(Base + 32'h0F0, rd);     check_eq("unmapped_read", rd, 32'd0);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_adr_i = Base + 32'h200;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.wbs_ack_o) acks++;
      end
      check_eq("no_decode_ack", 32'(acks), 32'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      tick();

      // Reset pulse while ch1 runs and a write strobe is held
      check_eq("pre_rst_irq", 32'(irq), 32'd2);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b1;
      bus.wbs_adr_i = ch_adr(0, 1);
      bus.wbs_dat_i = 32'h55;
      bus.wbs_sel_i = 4'hF;
      rst = 1'b1;
      tick();
      check_eq("rst_mid_ack", 32'(bus.wbs_ack_o), 32'd0);
      check_eq("rst_mid_irq", 32'(irq), 32'd0);
      check_eq("rst_mid_oeb", 32'(io_oeb), 32'h0000_FFFF);
      check_eq("rst_mid_out", 32'(io_out), 32'd0);
      rst = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      tick();
      wb_read(ch_adr(1, 2), rd);       check_eq("rst_ch1_count", rd, 32'd0);
      wb_read(ch_adr(1, 0), rd);       check_eq("rst_ch1_ctrl", rd, 32'd0);
      wb_read(ch_adr(0, 1), rd);       check_eq("rst_write_lost", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
